// File: rtl/error_counter_drv_if.sv
// error_counter_drv_if: AGC pulse inputs and active-low error-count lines of the error counter
interface error_counter_drv_if;
    logic _ECEN;
    logic _pECH;
    logic _mECH;
    logic _DD0, _DD1, _DD2, _DD3, _DD4, _DD5, _DD6, _DD7, _DD8;
    logic _ECSAT;
    logic _ECRATE;
    logic _ECZERO;

    modport master (
        output _ECEN, _pECH, _mECH,
        input  _DD0, _DD1, _DD2, _DD3, _DD4, _DD5, _DD6, _DD7, _DD8,
        input  _ECSAT, _ECRATE, _ECZERO
    );

    modport slave (
        input  _ECEN, _pECH, _mECH,
        output _DD0, _DD1, _DD2, _DD3, _DD4, _DD5, _DD6, _DD7, _DD8,
        output _ECSAT, _ECRATE, _ECZERO
    );
endinterface

// File: rtl/error_counter_drv.sv
// error_counter_drv: synchronised plus/minus pulse up/down counter driving the active-low _DD lines
// Defining ERRCTR_SATURATE_EN clamps the count to +/-LIMIT; otherwise it wraps in 9 bits.
module error_counter_drv #(
    parameter int LIMIT   = 255,
    parameter int MIN_GAP = 4
) (
    input logic clk,
    input logic rst_n,
    error_counter_drv_if.slave bus
);
`ifdef ERRCTR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic signed [8:0] LIM = 9'(LIMIT);
    localparam int GW = $clog2(MIN_GAP + 1);
    localparam logic [GW-1:0] GMAX = GW'(MIN_GAP);

    logic [1:0] en_q, p_q, m_q;
    logic p_d, m_d;
    logic signed [8:0] cnt, cnt_nx;
    logic [GW-1:0] gap, gap_nx;
    logic rate, rate_nx;
    logic en, pe, me, acc, at_hi, at_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '0;
            p_q  <= '0;
            m_q  <= '0;
            p_d  <= 1'b0;
            m_d  <= 1'b0;
            cnt  <= '0;
            gap  <= GMAX;
            rate <= 1'b0;
        end else begin
            en_q <= {en_q[0], bus._ECEN};
            p_q  <= {p_q[0], bus._pECH};
            m_q  <= {m_q[0], bus._mECH};
            p_d  <= p_q[1];
            m_d  <= m_q[1];
            cnt  <= cnt_nx;
            gap  <= gap_nx;
            rate <= rate_nx;
        end
    end

    assign en    = en_q[1];
    assign pe    = p_q[1] & ~p_d;
    assign me    = m_q[1] & ~m_d;
    assign acc   = en & (pe | me);
    assign at_hi = SAT && (cnt == LIM);
    assign at_lo = SAT && (cnt == -LIM);

    // Simultaneous plus and minus edges cancel but still count as one event for gap timing
    always_comb begin
        cnt_nx  = !en ? '0 :
                  (pe & ~me) ? (at_hi ? cnt : cnt + 9'sd1) :
                  (me & ~pe) ? (at_lo ? cnt : cnt - 9'sd1) : cnt;
        gap_nx  = acc ? '0 : (gap == GMAX) ? gap : gap + 1'b1;
        rate_nx = en & (rate | (acc & (gap < GMAX)));
    end

    assign {bus._DD8, bus._DD7, bus._DD6, bus._DD5, bus._DD4,
            bus._DD3, bus._DD2, bus._DD1, bus._DD0} = ~cnt;
    assign bus._ECSAT  = at_hi | at_lo;
    assign bus._ECRATE = rate;
    assign bus._ECZERO = (cnt == 9'sd0);
endmodule

// File: tb/tb_error_counter_drv.sv
// tb_error_counter_drv: directed vector table plus hand sequences for error_counter_drv
module tb_error_counter_drv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errs = 0;
    int checks = 0;
    int exp_c;

    always #5 clk = ~clk;

    error_counter_drv_if bus();
    error_counter_drv #(.LIMIT(255), .MIN_GAP(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic p;
        logic m;
        int   lo;
        int   cnt;
        logic rate;
    } vec_t;

    vec_t vecs[12];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic p, input logic m, input int hi, input int lo);
        bus._pECH = p;
        bus._mECH = m;
        tick(hi);
        bus._pECH = 1'b0;
        bus._mECH = 1'b0;
        tick(lo);
    endtask

    function automatic logic [8:0] dd();
        return {bus._DD8, bus._DD7, bus._DD6, bus._DD5, bus._DD4,
                bus._DD3, bus._DD2, bus._DD1, bus._DD0};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input int exp);
        logic [8:0] e;
        e = ~9'(exp);
        chk({nm, " dd"}, int'(dd()), int'(e));
        chk({nm, " zero"}, int'(bus._ECZERO), (exp == 0) ? 1 : 0);
    endtask

    initial begin
        bus._ECEN = 1'b0;
        bus._pECH = 1'b0;
        bus._mECH = 1'b0;
        vecs[0]  = '{1'b1, 1'b0, 9,  2, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 9,  3, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 9,  4, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 9,  5, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 9,  4, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 9,  3, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 9,  2, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 9,  1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 9,  0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 9, -1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 9, -2, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 9, -2, 1'b0};
        tick(2);
        chk("reset dd", int'(dd()), 'h1FF);
        chk("reset sat", int'(bus._ECSAT), 0);
        chk("reset rate", int'(bus._ECRATE), 0);
        chk("reset zero", int'(bus._ECZERO), 1);
        rst_n = 1'b1;
        bus._ECEN = 1'b1;
        tick(3);
        bus._pECH = 1'b1;
        tick(2);
        chk_cnt("latency2", 0);
        tick(1);
        chk_cnt("latency3", 1);
        bus._pECH = 1'b0;
        tick(7);
        for (int i = 0; i < 12; i++) begin
            pulse(vecs[i].p, vecs[i].m, 1, vecs[i].lo);
            chk_cnt($sformatf("vec%0d", i), vecs[i].cnt);
            chk($sformatf("vec%0d rate", i), int'(bus._ECRATE), int'(vecs[i].rate));
        end
        chk("five dd", int'(dd()), 'h001);
        pulse(1'b1, 1'b0, 1, 1);
        pulse(1'b1, 1'b0, 1, 6);
        chk_cnt("close pair", 0);
        chk("close pair rate", int'(bus._ECRATE), 1);
        bus._ECEN = 1'b0;
        tick(3);
        chk("disable dd", int'(dd()), 'h1FF);
        chk("disable rate", int'(bus._ECRATE), 0);
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0, 1, 9);
        chk_cnt("disabled pulses", 0);
        chk("disabled rate", int'(bus._ECRATE), 0);
        bus._ECEN = 1'b1;
        tick(3);
        bus._pECH = 1'b1;
        tick(50);
        bus._pECH = 1'b0;
        tick(5);
        chk_cnt("held high", 1);
        exp_c = 1;
        for (int i = 0; i < 300; i++) begin
            pulse(1'b1, 1'b0, 1, 4);
`ifdef ERRCTR_SATURATE_EN
            exp_c = (exp_c == 255) ? 255 : exp_c + 1;
`else
            exp_c = (exp_c == 255) ? -256 : exp_c + 1;
`endif
        end
        tick(4);
        chk_cnt("300 plus", exp_c);
        chk("300 plus rate", int'(bus._ECRATE), 0);
`ifdef ERRCTR_SATURATE_EN
        chk("300 plus sat", int'(bus._ECSAT), 1);
        chk("sat dd", int'(dd()), 'h100);
`else
        chk("300 plus sat", int'(bus._ECSAT), 0);
`endif
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        for (int i = 0; i < 100; i++) pulse(1'b1, 1'b0, 1, 4);
        tick(4);
        chk_cnt("count 100", 100);
        bus._pECH = 1'b1;
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset dd", int'(dd()), 'h1FF);
        chk("async reset zero", int'(bus._ECZERO), 1);
        tick(1);
        bus._pECH = 1'b0;
        rst_n = 1'b1;
        tick(3);
        pulse(1'b1, 1'b0, 1, 9);
        chk_cnt("post reset pulse", 1);
        chk("post reset rate", int'(bus._ECRATE), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
